trig_cfg_writer: RTL and testbench
==================================

# trig_cfg_writer

Host-side configuration writer for the per-channel trigger comparators. It consumes the byte stream from the host link decoder and decodes command bytes. It drives the shared 4-bit `wCMD` bus with one-hot per-channel `wEN` strobes, pulses `SetInit`, and owns the global trigger `EN`. It sits between the link receiver and the bank of NCH trigger comparators.

## Interface
- `NCH`, 8: number of trigger channels; even, 2..16.
- `TIMEOUT`, 65535: max idle cycles between bytes of a load sequence; 1..65535.
- `CLK` in 1: sole clock, all logic on posedge.
- `RST` in 1: synchronous, active-high reset.
- `RxData` in 8: byte from link decoder.
- `RxValid` in 1: `RxData` valid.
- `RxReady` out 1: byte accepted on a cycle with `RxValid & RxReady`.
- `wCMD` out 4: channel command nibble; {En, Mode, Lvl[1:0]}.
- `wEN` out NCH: one-hot write strobe; bit i loads `wCMD` into channel i.
- `SetInit` out 1: one-cycle pulse; clears all channel commands.
- `EN` out 1: global trigger enable; level.
- `Busy` out 1: high whenever the FSM is not in IDLE.
- `Err` out 1: one-cycle pulse on unknown opcode or load timeout.

## Operation
- Opcodes: 0xA0 LOAD, 0xA1 CLEAR, 0xA2 ARM, 0xA3 DISARM. Any other byte in IDLE is discarded and pulses `Err`.
- FSM states: IDLE, LOAD_RX, WR_LO, WR_HI, CLR.
- IDLE: `RxReady`=1.
  - LOAD -> LOAD_RX. Clear `EN`. Set byte index k=0 and the timeout counter to 0.
  - CLEAR -> CLR. Clear `EN`.
  - ARM: set `EN`=1 and stay in IDLE.
  - DISARM: set `EN`=0 and stay in IDLE.
- LOAD_RX: `RxReady`=1. Every accepted byte is data; there is no escape.
  - On accept: latch the byte and go to WR_LO.
  - No accept: increment the timeout counter. When it reaches `TIMEOUT`, pulse `Err` and go to IDLE. The partial load stays in the channels.
- WR_LO: `RxReady`=0, `wCMD`=byte[3:0], `wEN`=1<<(2k) -> WR_HI.
- WR_HI: `RxReady`=0, `wCMD`=byte[7:4], `wEN`=1<<(2k+1).
  - If k=NCH/2-1 -> IDLE.
  - Otherwise k++, reset the timeout counter, and go to LOAD_RX.
- CLR: `SetInit`=1 for exactly one cycle, `RxReady`=0 -> IDLE.
- `wEN` and `SetInit` are never asserted in the same cycle. The channel gives `wEN` priority, so overlap would be a bug.
- `wCMD` is 0 whenever `wEN` is 0.
- ARM while `Busy` cannot occur: opcodes are only decoded in IDLE.
- k is sized to clog2(NCH/2), minimum 1 bit. The timeout counter is 16 bits and never wraps; it saturates at `TIMEOUT`.

## Timing
- All outputs are registered.
- Reset values: `RxReady`=0 in the reset cycle and 1 from the first post-reset cycle. `wCMD`=0, `wEN`=0, `SetInit`=0, `EN`=0, `Busy`=0, `Err`=0. State is IDLE, k=0.
- Reset mid-load abandons the sequence without `Err`. Channels already written keep their commands.
- Opcode accepted at edge N: `EN` and `Busy` take their new value in cycle N+1.
- CLEAR accepted at edge N: `SetInit` high in cycle N+1; `RxReady` returns in cycle N+2.
- Data byte accepted at edge M:
  - cycle M+1: `wEN[2k]` high;
  - cycle M+2: `wEN[2k+1]` high;
  - cycle M+3: `RxReady`=1.
  - Each channel latches at the end of its strobe cycle.
- Full LOAD with back-to-back bytes: 1 + 3·NCH/2 cycles from opcode accept to IDLE.
- `Err` is high in the cycle after the offending accept, or after the timeout edge.
- Sustained throughput is one data byte per 3 cycles. `RxValid` held high is legal; the upstream side must hold `RxData` until accepted.

## Structure
- Shared package `trig_cfg_pkg`:
  - opcode localparams OP_LOAD/OP_CLEAR/OP_ARM/OP_DISARM;
  - FSM state encoding;
  - `wCMD` field positions (EN_BIT=3, MODE_BIT=2, LVL=[1:0]).
- Single module; no sub-module. The timeout counter and byte index are inline.

## Test plan
- Reset, then bytes A0,31,C4,D7,F5 with NCH=8 -> the 8 channels receive, in order, 1,3,4,C,7,D,5,F on successive cycles. Exactly one `wEN` bit per cycle; `Busy` falls after the last strobe; `EN`=0.
- A2 -> `EN`=1 the next cycle; then A1 -> `EN`=0 and a single-cycle `SetInit`, never overlapping `wEN`.
- Byte 0x55 in IDLE -> `Err` pulse for 1 cycle; no state change, `EN` unchanged.
- With TIMEOUT=10: A0,31 then silence -> channels 0,1 written, `Err` pulses 10 cycles after return to LOAD_RX, state IDLE. A following A2 -> `EN`=1.
- `RST` asserted in the WR_HI cycle -> next cycle all outputs are 0, `Busy`=0, no strobe for the pending channel, no `Err`.
- Random `RxValid` gaps during LOAD -> same channel writes as the back-to-back case; no byte is lost or duplicated while `RxReady`=0.

Source files
------------

// File: rtl/trig_cfg_pkg.sv
// Shared definitions for the trigger configuration writer: opcodes, FSM encoding
// and the field layout of the per-channel command nibble.
package trig_cfg_pkg;

  localparam logic [7:0] OP_LOAD   = 8'hA0;
  localparam logic [7:0] OP_CLEAR  = 8'hA1;
  localparam logic [7:0] OP_ARM    = 8'hA2;
  localparam logic [7:0] OP_DISARM = 8'hA3;

  // wCMD = {En, Mode, Lvl[1:0]}
  localparam int EN_BIT   = 3;
  localparam int MODE_BIT = 2;
  localparam int LVL_HI   = 1;
  localparam int LVL_LO   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_RX,
    ST_WR_LO,
    ST_WR_HI,
    ST_CLR
  } state_e;

endpackage

// File: rtl/trig_cfg_writer.sv
// Decodes host command bytes and writes per-channel trigger commands two nibbles
// per data byte over a shared wCMD bus with one-hot wEN strobes.
module trig_cfg_writer
  import trig_cfg_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [7:0]     RxData,
  input  logic           RxValid,
  output logic           RxReady,
  output logic [3:0]     wCMD,
  output logic [NCH-1:0] wEN,
  output logic           SetInit,
  output logic           EN,
  output logic           Busy,
  output logic           Err
);

  localparam int KW = (NCH / 2 > 1) ? $clog2(NCH / 2) : 1;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [15:0]      tmo_q;
  logic [3:0]       hi_q;
  logic             rdy_q, busy_q, en_q, err_q, setinit_q;
  logic [3:0]       wcmd_q;
  logic [NCH-1:0]   wen_q;

  logic acc;
  assign acc = RxValid & rdy_q;

  // Outputs are computed for the state being entered, so each one is a flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      tmo_q     <= '0;
      hi_q      <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      setinit_q <= 1'b0;
      wcmd_q    <= '0;
      wen_q     <= '0;
    end else begin
      wen_q     <= '0;
      wcmd_q    <= '0;
      setinit_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
          if (acc) begin
            case (RxData)
              OP_LOAD: begin
                state_q <= ST_LOAD_RX;
                en_q    <= 1'b0;
                k_q     <= '0;
                tmo_q   <= '0;
                busy_q  <= 1'b1;
              end
              OP_CLEAR: begin
                state_q   <= ST_CLR;
                en_q      <= 1'b0;
                busy_q    <= 1'b1;
                rdy_q     <= 1'b0;
                setinit_q <= 1'b1;
              end
              OP_ARM:    en_q  <= 1'b1;
              OP_DISARM: en_q  <= 1'b0;
              default:   err_q <= 1'b1;
            endcase
          end
        end
        ST_LOAD_RX: begin
          if (acc) begin
            state_q <= ST_WR_LO;
            hi_q    <= RxData[7:4];
            rdy_q   <= 1'b0;
            wcmd_q  <= RxData[3:0];
            wen_q   <= NCH'(1) << {k_q, 1'b0};
          end else if (tmo_q == 16'(TIMEOUT - 1)) begin
            // Abandon the load; channels already written keep their commands.
            state_q <= ST_IDLE;
            tmo_q   <= 16'(TIMEOUT);
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        ST_WR_LO: begin
          state_q <= ST_WR_HI;
          wcmd_q  <= hi_q;
          wen_q   <= NCH'(2) << {k_q, 1'b0};
        end
        ST_WR_HI: begin
          rdy_q <= 1'b1;
          if (k_q == KW'(NCH / 2 - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_LOAD_RX;
            k_q     <= k_q + KW'(1);
            tmo_q   <= '0;
          end
        end
        ST_CLR: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign RxReady = rdy_q;
  assign wCMD    = wcmd_q;
  assign wEN     = wen_q;
  assign SetInit = setinit_q;
  assign EN      = en_q;
  assign Busy    = busy_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_trig_cfg_writer.sv
// Directed bench for trig_cfg_writer: table of per-cycle vectors plus
// hand-written timeout, reset-in-load and gapped-load sequences.
module tb_trig_cfg_writer;
  localparam int NCH = 8;
  localparam int TMO = 10;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [7:0]     RxData = 8'h00;
  logic           RxValid = 1'b0;
  logic           RxReady;
  logic [3:0]     wCMD;
  logic [NCH-1:0] wEN;
  logic           SetInit, EN, Busy, Err;

  trig_cfg_writer #(.NCH(NCH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .wCMD(wCMD), .wEN(wEN), .SetInit(SetInit), .EN(EN), .Busy(Busy), .Err(Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, val;
    logic [7:0] d;
    logic rdy, busy, en, err, si;
    logic [3:0] cmd;
    logic [7:0] wen;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nerr = 0;

  function automatic vec_t V(input logic rst, val, input logic [7:0] d,
                             input logic rdy, busy, en, err, si,
                             input logic [3:0] cmd, input logic [7:0] wen);
    vec_t v;
    v.rst = rst; v.val = val; v.d = d; v.rdy = rdy; v.busy = busy; v.en = en;
    v.err = err; v.si = si; v.cmd = cmd; v.wen = wen;
    return v;
  endfunction

  function automatic logic [16:0] outs();
    return {RxReady, Busy, EN, Err, SetInit, wCMD, wEN};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [7:0]  bytes [5] = '{8'hA0, 8'h31, 8'hC4, 8'hD7, 8'hF5};
  logic [11:0] exp_w [8] = '{{4'h1, 8'h01}, {4'h3, 8'h02}, {4'h4, 8'h04}, {4'hC, 8'h08},
                             {4'h7, 8'h10}, {4'hD, 8'h20}, {4'h5, 8'h40}, {4'hF, 8'h80}};
  logic [11:0] got[$];
  int bad = 0;

  task automatic mon();
    if (wEN != '0) begin
      got.push_back({wCMD, wEN});
      if ($countones(wEN) != 1 || SetInit) bad++;
    end else if (wCMD != 4'h0) bad++;
  endtask

  initial begin
    //          rst val  d     rdy bsy en err si cmd   wen
    tbl.push_back(V(1, 0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 0, 8'h00, 1, 0, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'hA0, 1, 1, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'h31, 0, 1, 0, 0, 0, 4'h1, 8'h01));
    tbl.push_back(V(0, 1, 8'hC4, 0, 1, 0, 0, 0, 4'h3, 8'h02));
    tbl.push_back(V(0, 1, 8'hC4, 1, 1, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'hC4, 0, 1, 0, 0, 0, 4'h4, 8'h04));
    tbl.push_back(V(0, 1, 8'hD7, 0, 1, 0, 0, 0, 4'hC, 8'h08));
    tbl.push_back(V(0, 1, 8'hD7, 1, 1, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'hD7, 0, 1, 0, 0, 0, 4'h7, 8'h10));
    tbl.push_back(V(0, 1, 8'hF5, 0, 1, 0, 0, 0, 4'hD, 8'h20));
    tbl.push_back(V(0, 1, 8'hF5, 1, 1, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'hF5, 0, 1, 0, 0, 0, 4'h5, 8'h40));
    tbl.push_back(V(0, 0, 8'h00, 0, 1, 0, 0, 0, 4'hF, 8'h80));
    tbl.push_back(V(0, 0, 8'h00, 1, 0, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'hA2, 1, 0, 1, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'hA1, 0, 1, 0, 0, 1, 4'h0, 8'h00));
    tbl.push_back(V(0, 0, 8'h00, 1, 0, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'hA2, 1, 0, 1, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'h55, 1, 0, 1, 1, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 0, 8'h00, 1, 0, 1, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 1, 8'hA3, 1, 0, 0, 0, 0, 4'h0, 8'h00));
    tbl.push_back(V(0, 0, 8'h00, 1, 0, 0, 0, 0, 4'h0, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst; RxValid = tbl[i].val; RxData = tbl[i].d;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({tbl[i].rdy, tbl[i].busy, tbl[i].en, tbl[i].err, tbl[i].si, tbl[i].cmd, tbl[i].wen}));
    end

    // Load timeout after one data byte
    begin
      int n = 0;
      logic found = 1'b0;
      RxValid = 1; RxData = 8'hA0; tick();
      RxData = 8'h31; tick();
      chk("tmo_wrlo", 32'({wCMD, wEN}), 32'({4'h1, 8'h01}));
      RxValid = 0; RxData = 8'h00; tick();
      chk("tmo_wrhi", 32'({wCMD, wEN}), 32'({4'h3, 8'h02}));
      tick();
      chk("tmo_loadrx", 32'({RxReady, Busy, Err}), 32'(3'b110));
      while (!found && n < 40) begin
        tick(); n++;
        if (Err) found = 1'b1;
      end
      chk("tmo_cycles", 32'(n), 32'd10);
      chk("tmo_idle", 32'({RxReady, Busy, wEN}), 32'({1'b1, 1'b0, 8'h00}));
      tick();
      chk("tmo_errpulse", 32'(Err), 32'd0);
      RxValid = 1; RxData = 8'hA2; tick();
      RxValid = 0;
      chk("tmo_arm", 32'({EN, Busy}), 32'(2'b10));
    end

    // Reset asserted while in WR_HI
    RxValid = 1; RxData = 8'hA0; tick();
    RxData = 8'h31; tick();
    RxValid = 0; tick();
    chk("rst_inwrhi", 32'(wEN), 32'h02);
    RST = 1; tick();
    chk("rst_outs", 32'(outs()), 32'd0);
    RST = 0; tick();
    chk("rst_after", 32'(outs()), 32'(17'h10000));
    tick();
    chk("rst_noerr", 32'({Err, Busy, wEN}), 32'd0);

    // Load with random RxValid gaps
    begin
      int cyc = 0;
      logic acc;
      for (int b = 0; b < 5; b++) begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          RxValid = 0; RxData = 8'($urandom); tick(); cyc++; mon();
        end
        RxValid = 1; RxData = bytes[b]; acc = 1'b0;
        while (!acc && cyc < 300) begin
          acc = RxReady; tick(); cyc++; mon();
          if ($urandom_range(0, 2) == 0 && !acc) begin
            RxValid = 0; tick(); cyc++; mon(); RxValid = 1;
          end
        end
      end
      RxValid = 0;
      repeat (4) begin tick(); mon(); end
      chk("rnd_bound", 32'(cyc < 300), 32'd1);
      chk("rnd_count", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8; i++)
        chk($sformatf("rnd_w%0d", i), 32'(i < got.size() ? got[i] : 12'h000), 32'(exp_w[i]));
      chk("rnd_onehot", 32'(bad), 32'd0);
      chk("rnd_idle", 32'({Busy, Err, EN}), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
